inp_pio_debounce_edge: RTL and testbench

//  Multi-channel Avalon-MM input port for push-button/coin-slot inputs on the vending controller.
//  Per channel:
//   - 2-FF synchroniser, then counter debounce
//   - runtime-selectable rising/falling edge capture with W1C clear
//   - masked level interrupt to the Nios II

---
 rtl/inp_pio_debounce_edge.sv | 120 ++++++++++++
 tb/tb_inp_pio_debounce_edge.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/inp_pio_debounce_edge.sv
// Multi-channel Avalon-MM input PIO: per-channel 2-FF sync, counter debounce,
// selectable rise/fall edge capture with W1C clear, and a masked level irq.

module inp_pio_debounce_edge_lane #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic sync_in,
    output logic stable,
    output logic stable_d
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             s1;
    logic [CNT_W-1:0] cnt;

    // A new level is accepted only after DEB_CYCLES consecutive cycles of disagreement;
    // any return to the current stable level restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1       <= 1'b0;
            sync_in  <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            s1       <= raw;
            sync_in  <= s1;
            stable_d <= stable;
            if (sync_in == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync_in;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module inp_pio_debounce_edge #(
    parameter int               WIDTH      = 8,
    parameter int               DEB_CYCLES = 50000,
    parameter int               CNT_W      = 16,
    parameter logic [WIDTH-1:0] RISE_RST   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] FALL_RST   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] sync_in, stable, stable_d;
    logic [WIDTH-1:0] irq_mask, edge_cap, rise_en, fall_en;
    logic [WIDTH-1:0] edge_set, w1c, rd_mux;
    logic             wr;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        inp_pio_debounce_edge_lane #(
            .DEB_CYCLES(DEB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (in_port[i]),
            .sync_in (sync_in[i]),
            .stable  (stable[i]),
            .stable_d(stable_d[i])
        );
    end

    assign wr       = chipselect & ~write_n;
    assign edge_set = (stable & ~stable_d & rise_en) | (~stable & stable_d & fall_en);
    assign w1c      = (wr && address == 3'd3) ? writedata : '0;
    assign irq      = |(edge_cap & irq_mask);

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux = stable;
            3'd1:    rd_mux = sync_in;
            3'd2:    rd_mux = irq_mask;
            3'd3:    rd_mux = edge_cap;
            3'd4:    rd_mux = rise_en;
            3'd5:    rd_mux = fall_en;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
            rise_en  <= RISE_RST;
            fall_en  <= FALL_RST;
        end else begin
            readdata <= rd_mux;
            // Set is OR'd after the clear so a coincident edge is never lost.
            edge_cap <= (edge_cap & ~w1c) | edge_set;
            if (wr) begin
                case (address)
                    3'd2:    irq_mask <= writedata;
                    3'd4:    rise_en  <= writedata;
                    3'd5:    fall_en  <= writedata;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inp_pio_debounce_edge.sv
// Directed bench for inp_pio_debounce_edge: driver queues expected values,
// a negedge monitor pops and compares one cycle after each check request.

module tb_inp_pio_debounce_edge;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         chipselect;
    logic [2:0]   address;
    logic         write_n;
    logic [W-1:0] writedata;
    logic [W-1:0] readdata;
    logic [W-1:0] in_port;
    logic         irq;

    inp_pio_debounce_edge #(
        .WIDTH     (W),
        .DEB_CYCLES(4),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .chipselect(chipselect),
        .address   (address),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] exp_q[$];
    bit           kind_q[$];
    string        name_q[$];
    logic         chk_req = 1'b0;
    logic         chk_v   = 1'b0;
    logic [W-1:0] m_exp, m_got;
    bit           m_kind;
    string        m_name;

    always @(posedge clk) chk_v <= chk_req;

    always @(negedge clk) begin
        if (chk_v) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: got no expected entry, required one");
            end else begin
                m_exp  = exp_q.pop_front();
                m_kind = kind_q.pop_front();
                m_name = name_q.pop_front();
                m_got  = m_kind ? {{(W-1){1'b0}}, irq} : readdata;
                if (m_got !== m_exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", m_name, m_got, m_exp);
                end
            end
        end
    end

    // All driver tasks start at a negedge and end at the next negedge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [2:0] a, input logic [W-1:0] e, input string nm);
        address = a;
        chk_req = 1'b1;
        exp_q.push_back(e);
        kind_q.push_back(1'b0);
        name_q.push_back(nm);
        @(negedge clk);
        chk_req = 1'b0;
    endtask

    task automatic ck_irq(input logic e, input string nm);
        chk_req = 1'b1;
        exp_q.push_back({{(W-1){1'b0}}, e});
        kind_q.push_back(1'b1);
        name_q.push_back(nm);
        @(negedge clk);
        chk_req = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = '0;
        in_port    = 8'hFF;
        idle(2);

        // 1: inputs held high through reset; exact qualification latency
        rd(3'd0, 8'h00, "rst_readdata");
        ck_irq(1'b0, "rst_irq");
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) rd(3'd0, (k == 7) ? 8'hFF : 8'h00, "t1_deb_timing");
        rd(3'd3, 8'hFF, "t1_edge_cap");
        ck_irq(1'b0, "t1_irq_masked");
        rd(3'd1, 8'hFF, "t1_sync_in");

        // 2: 3-cycle glitch on bit0 must not qualify
        reset_n = 1'b0;
        in_port = 8'h00;
        idle(2);
        reset_n = 1'b1;
        idle(10);
        in_port = 8'h01;
        idle(3);
        in_port = 8'h00;
        idle(10);
        rd(3'd0, 8'h00, "t2_stable");
        rd(3'd3, 8'h00, "t2_edge_cap");

        // 3: masked rise raises irq, W1C clears it
        wr(3'd2, 8'h01);
        in_port = 8'h01;
        idle(10);
        ck_irq(1'b1, "t3_irq_set");
        rd(3'd3, 8'h01, "t3_edge_cap");
        wr(3'd3, 8'h01);
        ck_irq(1'b0, "t3_irq_clr");
        rd(3'd3, 8'h00, "t3_cap_clr");

        // 4: W1C in the same cycle as a new rise; set wins
        in_port = 8'h00;
        idle(10);
        rd(3'd3, 8'h00, "t4_pre");
        in_port = 8'h01;
        idle(6);
        wr(3'd3, 8'h01);
        ck_irq(1'b1, "t4_irq");
        rd(3'd3, 8'h01, "t4_set_wins");
        wr(3'd3, 8'hFF);

        // 5: fall-only capture on bit1
        wr(3'd4, 8'h00);
        wr(3'd5, 8'h02);
        in_port = 8'h03;
        idle(10);
        rd(3'd3, 8'h00, "t5_no_rise");
        in_port = 8'h01;
        idle(10);
        rd(3'd3, 8'h02, "t5_fall_cap");
        wr(3'd5, 8'h00);
        rd(3'd3, 8'h02, "t5_cap_kept");
        wr(3'd3, 8'hFF);
        rd(3'd3, 8'h00, "t5_cleared");
        in_port = 8'h03;
        idle(10);
        rd(3'd3, 8'h00, "t5_rise_ignored");
        rd(3'd0, 8'h03, "t5_stable");

        // 6: register readback, unused and RO addresses
        wr(3'd5, 8'hA5);
        rd(3'd5, 8'hA5, "t6_fall_en");
        rd(3'd6, 8'h00, "t6_addr6");
        wr(3'd0, 8'h00);
        rd(3'd0, 8'h03, "t6_ro_write");
        wr(3'd7, 8'hFF);
        rd(3'd7, 8'h00, "t6_addr7");
        rd(3'd4, 8'h00, "t6_rise_en");

        // 7: mid-operation reset with inputs held high re-qualifies
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(10);
        rd(3'd3, 8'h03, "t7_requal");
        rd(3'd5, 8'h00, "t7_fall_rst");
        rd(3'd4, 8'hFF, "t7_rise_rst");
        ck_irq(1'b0, "t7_mask_rst");
        wr(3'd2, 8'h02);
        ck_irq(1'b1, "t7_unmask");

        idle(2);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
